// File: rtl/dpll_ctrl.sv
// dpll_ctrl: all-digital PLL loop controller; measures DCO edges per reference window
// and steers a saturating DCO code with coarse/fine steps, lock and loss-of-lock flags.
module dpll_ctrl #(
  parameter int REF_DIV_WIDTH = 4,
  parameter int FB_DIV_WIDTH  = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int CODE_WIDTH    = 16,
  parameter logic [CODE_WIDTH-1:0] INIT_CODE = {1'b1, {(CODE_WIDTH-1){1'b0}}},
  parameter int GAIN_SHIFT    = 2,
  parameter int COARSE_THRESH = 4,
  parameter int LOCK_TOL      = 1,
  parameter int LOCK_WINDOWS  = 16
) (
  input  logic                        clk_ref_i,
  input  logic                        arst_ni,
  input  logic                        en_i,
  input  logic [REF_DIV_WIDTH-1:0]    ref_div_i,
  input  logic [FB_DIV_WIDTH-1:0]     fb_div_i,
  input  logic [CNT_WIDTH-1:0]        fb_cnt_gray_i,
  input  logic                        lol_clr_i,
  output logic [CODE_WIDTH-1:0]       dco_code_o,
  output logic                        update_o,
  output logic signed [CNT_WIDTH:0]   err_o,
  output logic                        locked_o,
  output logic                        lol_o,
  output logic                        sat_o
);
  localparam int SW  = CODE_WIDTH + CNT_WIDTH + 2;
  localparam int LCW = $clog2(LOCK_WINDOWS + 1);
  localparam logic [LCW-1:0] LCMAX = LCW'(LOCK_WINDOWS);
  localparam logic signed [SW-1:0] CMAX = SW'({CODE_WIDTH{1'b1}});
  typedef enum logic [1:0] {IDLE, BLANK, RUN} state_t;
  state_t state;
  logic [CNT_WIDTH-1:0] sync1, sync2, cnt_b, base, snap;
  logic [REF_DIV_WIDTH-1:0] ref_q, wcnt, wlast;
  logic [FB_DIV_WIDTH-1:0] fb_q, fb_eff;
  logic [LCW-1:0] lcnt, lcnt_n;
  logic snap_v, cfg_chg, wend, in_tol, coarse, clamp_hi, clamp;
  logic signed [CNT_WIDTH:0] e, e_abs;
  logic signed [SW-1:0] delta, sum;
  logic [CODE_WIDTH-1:0] code_n;
  always_comb begin
    cnt_b = '0;
    for (int i = 0; i < CNT_WIDTH; i++) cnt_b[i] = ^(sync2 >> i);
  end
  assign cfg_chg  = (ref_div_i != ref_q) || (fb_div_i != fb_q);
  assign wlast    = (ref_q == '0) ? '0 : ref_q - REF_DIV_WIDTH'(1);
  assign wend     = wcnt == wlast;
  assign fb_eff   = (fb_q == '0) ? FB_DIV_WIDTH'(1) : fb_q;
  assign e        = $signed({1'b0, CNT_WIDTH'(fb_eff)}) - $signed({1'b0, snap});
  assign e_abs    = e[CNT_WIDTH] ? -e : e;
  assign coarse   = e_abs > (CNT_WIDTH+1)'(COARSE_THRESH);
  assign in_tol   = e_abs <= (CNT_WIDTH+1)'(LOCK_TOL);
  assign delta    = coarse ? (SW'(e) <<< GAIN_SHIFT) : (e[CNT_WIDTH] ? {SW{1'b1}} : SW'(e != '0));
  assign sum      = delta + $signed(SW'(dco_code_o));
  assign clamp_hi = sum > CMAX;
  assign clamp    = sum[SW-1] || clamp_hi;
  assign code_n   = sum[SW-1] ? '0 : clamp_hi ? '1 : sum[CODE_WIDTH-1:0];
  assign lcnt_n   = (lcnt == LCMAX) ? lcnt : lcnt + LCW'(1);
  always_ff @(posedge clk_ref_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state      <= IDLE;
      sync1      <= '0;
      sync2      <= '0;
      ref_q      <= '0;
      fb_q       <= '0;
      wcnt       <= '0;
      base       <= '0;
      snap       <= '0;
      snap_v     <= 1'b0;
      lcnt       <= '0;
      dco_code_o <= INIT_CODE;
      update_o   <= 1'b0;
      err_o      <= '0;
      locked_o   <= 1'b0;
      lol_o      <= 1'b0;
      sat_o      <= 1'b0;
    end else begin
      sync1    <= fb_cnt_gray_i;
      sync2    <= sync1;
      ref_q    <= ref_div_i;
      fb_q     <= fb_div_i;
      update_o <= 1'b0;
      snap_v   <= 1'b0;
      if (lol_clr_i) lol_o <= 1'b0;
      if (!en_i) begin
        state    <= IDLE;
        wcnt     <= '0;
        lcnt     <= '0;
        locked_o <= 1'b0;
      end else if (state == IDLE || cfg_chg) begin
        // a fresh or reconfigured loop discards its first window
        state    <= BLANK;
        wcnt     <= '0;
        base     <= cnt_b;
        lcnt     <= '0;
        locked_o <= 1'b0;
      end else begin
        wcnt <= wend ? '0 : wcnt + REF_DIV_WIDTH'(1);
        if (wend) begin
          base   <= cnt_b;
          snap   <= cnt_b - base;
          snap_v <= state == RUN;
          state  <= RUN;
        end
        if (snap_v) begin
          dco_code_o <= code_n;
          sat_o      <= clamp;
          err_o      <= e;
          update_o   <= 1'b1;
          if (in_tol) begin
            lcnt     <= lcnt_n;
            locked_o <= lcnt_n == LCMAX;
          end else begin
            lcnt     <= '0;
            locked_o <= 1'b0;
            if (locked_o) lol_o <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dpll_ctrl.sv
// tb_dpll_ctrl: randomized self-checking bench for dpll_ctrl against a per-window loop model.
module tb_dpll_ctrl;
  logic clk_ref_i = 1'b0, arst_ni = 1'b0, en_i = 1'b0, lol_clr_i = 1'b0;
  logic [3:0] ref_div_i = 4'd4;
  logic [7:0] fb_div_i = 8'd10;
  logic [15:0] bcnt = '0, fb_cnt_gray_i, dco_code_o;
  logic signed [16:0] err_o;
  logic update_o, locked_o, lol_o, sat_o;
  int n_chk = 0, n_pass = 0;
  int m_code = 32768, m_cnt = 0, m_w = 4, m_t = 10, m_err = 0;
  bit m_locked = 0, m_lol = 0, m_sat = 0;
  dpll_ctrl dut (
    .clk_ref_i(clk_ref_i), .arst_ni(arst_ni), .en_i(en_i), .ref_div_i(ref_div_i),
    .fb_div_i(fb_div_i), .fb_cnt_gray_i(fb_cnt_gray_i), .lol_clr_i(lol_clr_i),
    .dco_code_o(dco_code_o), .update_o(update_o), .err_o(err_o),
    .locked_o(locked_o), .lol_o(lol_o), .sat_o(sat_o)
  );
  assign fb_cnt_gray_i = bcnt ^ (bcnt >> 1);
  always #5 clk_ref_i = ~clk_ref_i;
  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
  endtask
  task automatic model_update(input int meas);
    int e, d, c;
    e = m_t - meas;
    d = (e > 4 || e < -4) ? e * 4 : (e > 0 ? 1 : (e < 0 ? -1 : 0));
    c = m_code + d;
    m_sat = c < 0 || c > 65535;
    m_code = c < 0 ? 0 : (c > 65535 ? 65535 : c);
    m_err = e;
    if (e >= -1 && e <= 1) begin
      m_cnt = m_cnt < 16 ? m_cnt + 1 : 16;
      m_locked = m_cnt == 16;
    end else begin
      if (m_locked) m_lol = 1;
      m_cnt = 0;
      m_locked = 0;
    end
  endtask
  task automatic quiet(input int k);
    repeat (k) begin
      @(negedge clk_ref_i);
      chk("no_update", update_o, 0);
      chk("code_held", dco_code_o, m_code);
    end
  endtask
  task automatic start_cfg(input int w, input int t);
    ref_div_i = 4'(w);
    fb_div_i = 8'(t);
    en_i = 1'b1;
    m_w = w;
    m_t = t == 0 ? 1 : t;
    m_cnt = 0;
    m_locked = 0;
    repeat (w + 2) begin
      @(negedge clk_ref_i);
      chk("blank_update", update_o, 0);
      chk("blank_code", dco_code_o, m_code);
      chk("blank_locked", locked_o, 0);
      chk("blank_lol", lol_o, m_lol);
    end
  endtask
  task automatic window(input int meas, input bit clr);
    bcnt = bcnt + 16'(meas);
    lol_clr_i = clr;
    if (clr) m_lol = 0;
    for (int i = 1; i <= m_w; i++) begin
      @(negedge clk_ref_i);
      if (i < m_w) chk("win_no_update", update_o, 0);
    end
    model_update(meas);
    chk("update", update_o, 1);
    chk("err", err_o, m_err);
    chk("code", dco_code_o, m_code);
    chk("sat", sat_o, m_sat);
    chk("locked", locked_o, m_locked);
    chk("lol", lol_o, m_lol);
    lol_clr_i = 1'b0;
  endtask
  task automatic disable_loop();
    en_i = 1'b0;
    m_cnt = 0;
    m_locked = 0;
    repeat (3) begin
      @(negedge clk_ref_i);
      chk("dis_update", update_o, 0);
      chk("dis_locked", locked_o, 0);
    end
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_code"}, dco_code_o, 32768);
    chk({tag, "_update"}, update_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_locked"}, locked_o, 0);
    chk({tag, "_lol"}, lol_o, 0);
    chk({tag, "_sat"}, sat_o, 0);
  endtask
  initial begin
    int w, t, nw, mm;
    #12 check_reset_vals("rst");
    @(negedge clk_ref_i);
    arst_ni = 1'b1;
    quiet(2);
    // lock acquisition with a perfectly matched DCO
    start_cfg(4, 10);
    for (int k = 0; k < 16; k++) window(10, 0);
    chk("locked_16", locked_o, 1);
    chk("lock_code", dco_code_o, 32768);
    window(14, 0);
    chk("lol_set", lol_o, 1);
    window(10, 1);
    chk("lol_clr", lol_o, 0);
    for (int k = 0; k < 16; k++) window(10, 0);
    window(14, 1);
    chk("lol_set_wins", lol_o, 1);
    window(10, 1);
    for (int k = 0; k < 16; k++) window(10, 0);
    start_cfg(4, 12);
    chk("cfg_lol", lol_o, 0);
    for (int k = 0; k < 3; k++) window(12, 0);
    // asynchronous reset in the middle of a window
    bcnt = bcnt + 16'd12;
    quiet(2);
    arst_ni = 1'b0;
    en_i = 1'b0;
    #1 check_reset_vals("midrst");
    m_code = 32768; m_sat = 0; m_lol = 0; m_locked = 0; m_cnt = 0; m_err = 0;
    @(negedge clk_ref_i);
    arst_ni = 1'b1;
    quiet(4);
    start_cfg(4, 10);
    window(2, 0);
    chk("coarse_code", dco_code_o, 32800);
    window(12, 0);
    chk("fine_code", dco_code_o, 32799);
    chk("fine_sat", sat_o, 0);
    // config change landing on the snapshot edge
    bcnt = bcnt + 16'd3;
    quiet(m_w - 2);
    start_cfg(4, 11);
    window(11, 0);
    // disable landing on the update edge
    bcnt = bcnt + 16'd20;
    quiet(m_w - 1);
    en_i = 1'b0;
    m_cnt = 0;
    m_locked = 0;
    quiet(3);
    bcnt = 16'hFFFE;
    start_cfg(4, 10);
    window(10, 0);
    chk("wrap_err", err_o, 0);
    disable_loop();
    start_cfg(4, 200);
    for (int k = 0; k < 45; k++) window(0, 0);
    chk("sat_hi_code", dco_code_o, 65535);
    chk("sat_hi_flag", sat_o, 1);
    disable_loop();
    start_cfg(5, 1);
    for (int k = 0; k < 70; k++) window(255, 0);
    chk("sat_lo_code", dco_code_o, 0);
    chk("sat_lo_flag", sat_o, 1);
    for (int ep = 0; ep < 20; ep++) begin
      disable_loop();
      w = $urandom_range(4, 15);
      t = (ep == 3) ? 0 : $urandom_range(1, 255);
      start_cfg(w, t);
      nw = $urandom_range(5, 30);
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 9) < 7) mm = m_t + int'($urandom_range(0, 4)) - 2;
        else mm = int'($urandom_range(0, 300));
        if (mm < 0) mm = 0;
        window(mm, $urandom_range(0, 7) == 0);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dpll_ctrl.md
# dpll_ctrl

All-digital PLL loop controller, clocked by the reference clock. Each reference window it measures the feedback (DCO) edge count and compares it with the programmed ratio. It then updates a saturating DCO control code using coarse or fine steps, and reports lock, sticky loss-of-lock and saturation. It is the synthesizable, parametrised successor to the behavioural PLL model: a real DCO takes `dco_code_o` and returns its free-running Gray-coded edge counter.

## Interface
- `REF_DIV_WIDTH`, default 4: width of the reference-window divider.
- `FB_DIV_WIDTH`, default 8: width of the feedback ratio.
- `CNT_WIDTH`, default 16: width of the DCO edge counter; must be ≥ `FB_DIV_WIDTH`+2.
- `CODE_WIDTH`, default 16: width of the DCO control code.
- `INIT_CODE`, default 2^(`CODE_WIDTH`-1): code value at reset.
- `GAIN_SHIFT`, default 2: left shift of the error in coarse mode.
- `COARSE_THRESH`, default 4: |error| above this value selects coarse mode.
- `LOCK_TOL`, default 1: |error| ≤ this value counts as in-tolerance.
- `LOCK_WINDOWS`, default 16: consecutive in-tolerance windows needed to assert lock.
- `clk_ref_i` input 1: reference clock.
- `arst_ni` input 1: reset, asynchronous, active-low.
- `en_i` input 1: loop enable.
- `ref_div_i` input `REF_DIV_WIDTH`: window length W in reference cycles; 0 is treated as 1.
- `fb_div_i` input `FB_DIV_WIDTH`: target DCO edges per window T; 0 is treated as 1.
- `fb_cnt_gray_i` input `CNT_WIDTH`: Gray-coded free-running DCO edge counter, asynchronous to `clk_ref_i`.
- `lol_clr_i` input 1: clears the sticky `lol_o`.
- `dco_code_o` output `CODE_WIDTH`: DCO control code.
- `update_o` output 1: one-cycle pulse, asserted in the cycle `dco_code_o` is loaded.
- `err_o` output `CNT_WIDTH`+1: signed error T − measured from the last window.
- `locked_o` output 1: lock indication.
- `lol_o` output 1: sticky loss-of-lock.
- `sat_o` output 1: the last update clamped the code.

## Operation
- **Input sync:** `fb_cnt_gray_i` passes through a 2-FF synchronizer, then Gray-to-binary conversion, giving `cnt_b`.
- **Config change:** `ref_div_i` and `fb_div_i` are registered every cycle as `ref_q` and `fb_q`. A mismatch between input and register is a config change.
- **FSM states:**
  - IDLE: entered on reset or `en_i`=0. Window counter cleared, lock count cleared, `locked_o`=0, code held.
  - BLANK: entered on `en_i` rising or on a config change. Runs one window whose measurement is discarded; base ← `cnt_b`.
  - RUN: contiguous measurement windows.
- **Transitions:**
  - `en_i`=0 → IDLE from any state.
  - Config change → BLANK from any state except IDLE.
  - BLANK end → RUN.
- **Window counter:** counts 0..W-1. In the cycle it equals W-1:
  - snapshot ← `cnt_b` − base, modulo 2^`CNT_WIDTH`;
  - base ← `cnt_b`.
  - Windows are therefore gapless.
- **Update:** the cycle after a RUN snapshot:
  - error e = T − snapshot, signed `CNT_WIDTH`+1 bits.
  - If |e| > `COARSE_THRESH`: delta = e <<< `GAIN_SHIFT`.
  - Otherwise: delta = sign(e), i.e. ±1 or 0.
  - code ← clamp(code + delta, 0, 2^`CODE_WIDTH`-1), computed in `CODE_WIDTH`+`CNT_WIDTH`+2 signed bits.
  - `sat_o` is set if the clamp was applied, cleared otherwise.
  - `err_o` ← e; `update_o`=1.
- **Lock:**
  - |e| ≤ `LOCK_TOL` increments the lock count, saturating at `LOCK_WINDOWS`. `locked_o`=1 when count = `LOCK_WINDOWS`.
  - |e| > `LOCK_TOL` clears the count and `locked_o`. If `locked_o` was 1, `lol_o` is set.
- **Loss-of-lock exclusions:** config change and disable clear lock without setting `lol_o`.
- **`lol_o` clear:** cleared by `lol_clr_i`. A simultaneous set wins over the clear.

## Timing
- **Reset values:**
  - `dco_code_o`=`INIT_CODE`
  - `update_o`=0, `err_o`=0, `locked_o`=0, `lol_o`=0, `sat_o`=0
  - FSM=IDLE; all counters and sync flops 0.
- **Latencies:**
  - Counter input to `cnt_b`: 2 cycles.
  - Snapshot to `dco_code_o`/`update_o`: 1 cycle.
  - Window period: W cycles.
- **Earliest first update:** W (BLANK) + W + 1 cycles after enable.
- **Earliest lock:** after `LOCK_WINDOWS` in-tolerance RUN windows.
- **Simultaneous events:**
  - Config change in the snapshot cycle: the snapshot is discarded, no update, BLANK restarts.
  - `en_i` falling in the update cycle: the update is suppressed.
- **Mid-operation reset:** `arst_ni` asserted mid-window immediately forces all reset values.
- **Wrap-around:** counter wrap is absorbed by the modulo subtraction.

## Test plan
- **Lock:** W=4, T=10, DCO counter +10 per window, `en_i`=1 → first `update_o` at cycle 9 after enable, code stays 32768, `err_o`=0, `locked_o` rises after the 16th RUN window.
- **Coarse/fine:**
  - Measured 2 with T=10 → e=+8, code 32768→32800.
  - Measured 12 → e=−2, code −1, `sat_o`=0.
- **Saturation:** measured 0, T=200, repeated → code climbs by 800 per window, clamps at 65535 with `sat_o`=1, never wraps.
- **Loss of lock:** while locked, one window measures 14 with T=10 → `locked_o`=0, `lol_o`=1. `lol_clr_i` pulse → `lol_o`=0.
- **Config change:**
  - Change `fb_div_i` 10→12 while locked → `locked_o`=0, `lol_o` stays 0, no `update_o` for the next BLANK window, code held.
  - Counter wrap 0xFFFE→0x0008 across a window reads measured=10.
- **Reset mid-window:** `arst_ni` low at window cycle 2 → all outputs return to reset values immediately; after release the loop resumes in IDLE.
